// File: rtl/uart_tx_arb.sv
// Round-robin arbiter feeding three byte sources into one UART transmitter.
// Optional REQ-state timeout is enabled by defining UART_TX_ARB_TIMEOUT_EN.
`timescale 1ns/1ps

module uart_tx_arb (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  req_valid,
  input  logic [23:0] req_data,
  output logic [2:0]  req_ready,
  input  logic        tx_busy,
  output logic        tx_req,
  output logic [7:0]  byte_out,
  output logic [1:0]  grant_id,
  output logic        timeout_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    XMIT = 2'd2
  } state_t;

  state_t      state_r, state_s;
  logic        tx_req_r, tx_req_s;
  logic [7:0]  byte_r, byte_s;
  logic [1:0]  grant_r, grant_s;
  logic [1:0]  last_r, last_s;
  logic [1:0]  win_s, cand_s;
  logic        found_s;
  logic        can_grant_s;
`ifdef UART_TX_ARB_TIMEOUT_EN
  logic [7:0]  cnt_r, cnt_s;
  logic        terr_r, terr_s;
`endif

  function automatic logic [1:0] next_idx(input logic [1:0] idx);
    case (idx)
      2'd0:    next_idx = 2'd1;
      2'd1:    next_idx = 2'd2;
      default: next_idx = 2'd0;
    endcase
  endfunction

  // Round-robin search starting one past the last completed grant
  always_comb begin
    win_s   = 2'd0;
    found_s = 1'b0;
    cand_s  = next_idx(last_r);
    for (int k = 0; k < 3; k++) begin
      if (!found_s && req_valid[cand_s]) begin
        win_s   = cand_s;
        found_s = 1'b1;
      end else begin
        found_s = found_s;
      end
      cand_s = next_idx(cand_s);
    end
  end

  assign can_grant_s = rst_n && (state_r == IDLE) && !tx_busy && found_s;

  // One-hot ready for the winner only while a grant is possible
  always_comb begin
    req_ready = 3'b000;
    if (can_grant_s) begin
      case (win_s)
        2'd0:    req_ready = 3'b001;
        2'd1:    req_ready = 3'b010;
        2'd2:    req_ready = 3'b100;
        default: req_ready = 3'b000;
      endcase
    end else begin
      req_ready = 3'b000;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_s  = state_r;
    tx_req_s = tx_req_r;
    byte_s   = byte_r;
    grant_s  = grant_r;
    last_s   = last_r;
`ifdef UART_TX_ARB_TIMEOUT_EN
    cnt_s    = cnt_r;
    terr_s   = 1'b0;
`endif
    case (state_r)
      IDLE: begin
        if (can_grant_s) begin
          byte_s   = req_data[{win_s, 3'b000} +: 8];
          grant_s  = win_s;
          tx_req_s = 1'b1;
          state_s  = REQ;
`ifdef UART_TX_ARB_TIMEOUT_EN
          cnt_s    = 8'd0;
`endif
        end else begin
          state_s = IDLE;
        end
      end
      REQ: begin
        if (tx_busy) begin
          tx_req_s = 1'b0;
          state_s  = XMIT;
        end
`ifdef UART_TX_ARB_TIMEOUT_EN
        // Transmitter never answered: drop the byte and move the pointer on
        else if (cnt_r == 8'd255) begin
          tx_req_s = 1'b0;
          terr_s   = 1'b1;
          last_s   = grant_r;
          state_s  = IDLE;
        end else begin
          cnt_s = cnt_r + 8'd1;
        end
`else
        else begin
          state_s = REQ;
        end
`endif
      end
      XMIT: begin
        if (!tx_busy) begin
          last_s  = grant_r;
          state_s = IDLE;
        end else begin
          state_s = XMIT;
        end
      end
      default: begin
        tx_req_s = 1'b0;
        state_s  = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r  <= IDLE;
      tx_req_r <= 1'b0;
      byte_r   <= 8'h00;
      grant_r  <= 2'd0;
      last_r   <= 2'd2;
    end else begin
      state_r  <= state_s;
      tx_req_r <= tx_req_s;
      byte_r   <= byte_s;
      grant_r  <= grant_s;
      last_r   <= last_s;
    end
  end

`ifdef UART_TX_ARB_TIMEOUT_EN
  // Timeout counter and error pulse registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_r  <= 8'd0;
      terr_r <= 1'b0;
    end else begin
      cnt_r  <= cnt_s;
      terr_r <= terr_s;
    end
  end

  assign timeout_err = terr_r;
`else
  assign timeout_err = 1'b0;
`endif

  assign tx_req   = tx_req_r;
  assign byte_out = byte_r;
  assign grant_id = grant_r;

endmodule

// File: doc/uart_tx_arb.md
UART_TX_ARB -- requirements
Module: uart_tx_arb

Interface
REQ-001 SHALL have port clk  in  1  single clock; all logic on rising edge.
REQ-002 SHALL have port rst_n  in  1  reset, synchronous, active-low.
REQ-003 SHALL have port req_valid  in  3  per-source byte-valid; bit i = source i.
REQ-004 SHALL have port req_data  in  24  source i byte at [8i+7:8i]; held stable while req_valid[i]=1.
REQ-005 SHALL have port req_ready  out  3  one-hot accept; transfer when req_valid[i]&req_ready[i].
REQ-006 SHALL have port tx_busy  in  1  UART transmitter busy.
REQ-007 SHALL have port tx_req  out  1  send request to transmitter, level.
REQ-008 SHALL have port byte_out  out  8  byte presented to transmitter.
REQ-009 SHALL have port grant_id  out  2  source index of the current/last byte.
REQ-010 SHALL have port timeout_err  out  1  one-cycle pulse on aborted request.

Function
REQ-011 SHALL implement states IDLE, REQ, XMIT; reset state IDLE.
REQ-012 SHALL, in IDLE with tx_busy=0 and any req_valid, select a winner round-robin, searching from (last_grant+1) mod 3 upward with wrap.
REQ-013 SHALL drive req_ready combinationally: winner bit only, only in IDLE with tx_busy=0 and rst_n=1; else 3'b000.
REQ-014 SHALL, on accept, register byte_out<=winner data, grant_id<=winner, tx_req<=1, state<=REQ; tx_req high the cycle after accept.
REQ-015 SHALL not grant in IDLE while tx_busy=1 (external transmitter use).
REQ-016 SHALL, in REQ, hold tx_req=1 and byte_out stable until tx_busy sampled 1, then tx_req<=0, state<=XMIT.
REQ-017 SHALL, in XMIT, wait for tx_busy sampled 0, then last_grant<=grant_id, state<=IDLE.
REQ-018 SHALL insert at least one IDLE cycle between consecutive grants.
REQ-019 SHALL hold byte_out and grant_id between transfers.
REQ-020 SHALL accept exactly one byte per grant; a source dropping req_valid before ready loses nothing and is not granted.
REQ-021 SHALL ignore tx_busy glitches in IDLE beyond REQ-015; no state change.

Reset
REQ-022 SHALL, when rst_n=0 at a clock edge, set state=IDLE, tx_req=0, byte_out=8'h00, grant_id=2'd0, last_grant=2'd2, timeout_err=0, timeout counter=0.
REQ-023 SHALL abort any in-flight REQ/XMIT on reset without further output; first grant after reset goes to source 0 if valid.
REQ-024 SHALL keep req_ready=0 during any cycle rst_n=0.

Configuration
REQ-025 SHALL support macro UART_TX_ARB_TIMEOUT_EN.
REQ-026 SHALL, with UART_TX_ARB_TIMEOUT_EN defined, count cycles in REQ with an 8-bit counter cleared on REQ entry; at count 255 without tx_busy: tx_req<=0, timeout_err=1 for one cycle, last_grant<=grant_id, state<=IDLE (byte dropped).
REQ-027 SHALL, without UART_TX_ARB_TIMEOUT_EN, wait in REQ indefinitely and tie timeout_err to 0.

Verification
REQ-028 SHALL cover: reset, req_valid=3'b001, data 8'h41 -> req_ready=3'b001 same cycle, next cycle tx_req=1, byte_out=8'h41, grant_id=0; tx_busy rises -> tx_req=0 next cycle.
REQ-029 SHALL cover: all three valid continuously (8'h10/8'h20/8'h30), transmitter model busy 10 cycles per byte -> byte_out sequence 10,20,30,10,... grant_id 0,1,2,0.
REQ-030 SHALL cover: tx_busy=1 held in IDLE with req_valid=3'b010 -> req_ready=0 until tx_busy=0, then grant source 1.
REQ-031 SHALL cover: rst_n=0 for one cycle while in XMIT -> next cycle tx_req=0, state IDLE, byte_out=8'h00; pending source 0 granted first.
REQ-032 SHALL cover: timeout build, tx_busy stuck 0 after grant -> tx_req falls and timeout_err pulses exactly once 255 cycles after REQ entry; next grant rotates to following source; non-timeout build -> tx_req stays 1, timeout_err 0.
